// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver state encoding, word width and the
// line timing defaults used by both the transmitter and the receiver.
package ws2812_pkg;

  localparam int unsigned WORD_W   = 24;
  localparam int unsigned T_ON     = 9;
  localparam int unsigned T_OFF    = 4;
  localparam int unsigned T_PERIOD = 14;

  typedef enum logic [1:0] {
    WAIT_RESET,
    IDLE,
    HIGH,
    LOW
  } rx_state_t;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the WS2812 line with registered edge detect.
// Ports: clk, reset (sync, active-high), din (async line),
//        din_s (synchronized line), rise / fall (one-cycle edge pulses).
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic din_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b0;
      din_s <= 1'b0;
      din_q <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= din;
      din_s <= meta;
      din_q <= din_s;
      rise  <= din_s & ~din_q;
      fall  <= ~din_s & din_q;
    end
  end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 stream receiver: classifies high pulses by width into bits, builds
// 24-bit MSB-first words tagged with their arrival index, and flags frame
// end on a long low gap.
// Ports: clk, reset (sync, active-high), din (async line),
//        rgb_data / led_num (last word and its index), valid, frame_done,
//        error (one-cycle pulses), dout (forwarded line).
// Optional feature: define WS2812_RX_FORWARD_EN to forward the stream past
// the first NUM_LEDS words on dout; otherwise dout is tied low.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned T_BIT_THRESH = (T_ON + T_OFF) / 2,
  parameter int unsigned MIN_HIGH     = 2,
  parameter int unsigned MAX_HIGH     = 20,
  parameter int unsigned T_RESET_DET  = 500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic [WORD_W-1:0] rgb_data,
  output logic [7:0]        led_num,
  output logic              valid,
  output logic              frame_done,
  output logic              error,
  output logic              dout
);

  localparam int unsigned CNT_W  = $clog2(T_RESET_DET + 1);
  localparam int unsigned WCNT_W = $clog2(NUM_LEDS + 1);
  localparam int unsigned BCNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              din_s;
  logic              rise;
  logic              fall;
  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic              line_hi;
  logic [WORD_W-2:0] sreg;
  logic [BCNT_W-1:0] bit_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic              bit_val;
  logic [WORD_W-1:0] word_next;

  ws2812_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  // Decoded bit and the word it would complete, from the current pulse width.
  always_comb begin
    bit_val   = (cnt >= CNT_W'(T_BIT_THRESH));
    word_next = {sreg, bit_val};
  end

  // Width counter, line level tracker and receive FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_RESET;
      cnt        <= '0;
      line_hi    <= 1'b0;
      sreg       <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      rgb_data   <= '0;
      led_num    <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      valid      <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;

      // The edge cycle is the first cycle of the new level, so cnt equals
      // the level width when the opposite edge arrives.
      if (rise || fall) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      if (rise) begin
        line_hi <= 1'b1;
      end else if (fall) begin
        line_hi <= 1'b0;
      end

      case (state)
        WAIT_RESET: begin
          bit_cnt  <= '0;
          word_cnt <= '0;
          // Only a low run counts toward the gap; a high run may also saturate cnt.
          if (!line_hi && !rise && cnt >= CNT_W'(T_RESET_DET)) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (rise) begin
            state <= HIGH;
          end
        end

        HIGH: begin
          if (cnt > CNT_W'(MAX_HIGH)) begin
            error   <= 1'b1;
            bit_cnt <= '0;
            state   <= WAIT_RESET;
          end else if (fall) begin
            state <= LOW;
            if (cnt < CNT_W'(MIN_HIGH)) begin
              error <= 1'b1;
            end else begin
              sreg <= word_next[WORD_W-2:0];
              if (bit_cnt == BCNT_W'(WORD_W - 1)) begin
                bit_cnt <= '0;
                if (word_cnt < WCNT_W'(NUM_LEDS)) begin
                  rgb_data <= word_next;
                  led_num  <= 8'(word_cnt);
                  valid    <= 1'b1;
                  word_cnt <= word_cnt + 1'b1;
                end else begin
                  error <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

        LOW: begin
          if (rise) begin
            state <= HIGH;
          end else if (cnt >= CNT_W'(T_RESET_DET)) begin
            frame_done <= 1'b1;
            if (bit_cnt != '0) begin
              error <= 1'b1;
            end
            bit_cnt  <= '0;
            word_cnt <= '0;
            state    <= IDLE;
          end
        end

        default: state <= WAIT_RESET;
      endcase
    end
  end

`ifdef WS2812_RX_FORWARD_EN
  // Pass the line downstream once this chain segment has taken its words.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= 1'b0;
    end else begin
      dout <= (word_cnt >= WCNT_W'(NUM_LEDS)) ? din_s : 1'b0;
    end
  end
`else
  logic unused_din_s;
  assign unused_din_s = din_s;
  assign dout         = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomized self-checking bench for ws2812_rx: drives pulse trains on din
// and compares observed words, indices, errors and frame ends against a
// pulse-level reference decoder.
module tb_ws2812_rx;

  localparam int NUM_LEDS = 8;
  localparam int T_THR    = 6;
  localparam int T_MIN    = 2;
  localparam int T_MAX    = 20;
  localparam int T_GAP    = 500;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        valid;
  logic        frame_done;
  logic        error;
  logic        dout;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed events
  logic [31:0] got_q[$];
  int          got_err = 0;
  int          got_fd  = 0;
  int          dout_hi = 0;

  // Reference decoder state
  logic [31:0] exp_q[$];
  int          exp_err = 0;
  int          exp_fd  = 0;
  bit          m_ready = 0;
  bit          m_active = 0;
  int          m_bits = 0;
  int          m_words = 0;
  logic [23:0] m_sreg = '0;

  always #5 clk = ~clk;

  ws2812_rx dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .rgb_data   (rgb_data),
    .led_num    (led_num),
    .valid      (valid),
    .frame_done (frame_done),
    .error      (error),
    .dout       (dout)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (valid) got_q.push_back({led_num, rgb_data});
      if (error) got_err++;
      if (frame_done) got_fd++;
      if (dout) dout_hi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  // Reference: one high pulse of hi cycles, interpreted by width alone.
  task automatic model_pulse(input int hi);
    if (m_ready) begin
      m_active = 1;
      if (hi > T_MAX) begin
        exp_err++;
        m_bits   = 0;
        m_ready  = 0;
        m_active = 0;
      end else if (hi < T_MIN) begin
        exp_err++;
      end else begin
        m_sreg = {m_sreg[22:0], (hi >= T_THR)};
        m_bits++;
        if (m_bits == 24) begin
          m_bits = 0;
          if (m_words < NUM_LEDS) begin
            exp_q.push_back({8'(m_words), m_sreg});
            m_words++;
          end else begin
            exp_err++;
          end
        end
      end
    end
  endtask

  // Reference: a low run of at least the reset gap.
  task automatic model_gap();
    if (!m_ready) begin
      m_ready = 1;
    end else if (m_active) begin
      exp_fd++;
      if (m_bits != 0) exp_err++;
    end
    m_bits   = 0;
    m_words  = 0;
    m_active = 0;
  endtask

  task automatic model_reset();
    m_ready  = 0;
    m_active = 0;
    m_bits   = 0;
    m_words  = 0;
  endtask

  task automatic send_pulse(input int hi, input int lo);
    model_pulse(hi);
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  task automatic send_bit(input bit b, input bit std);
    int hi, lo;
    if (std) begin
      hi = b ? 9 : 4;
      lo = 14 - hi;
    end else begin
      hi = b ? int'($urandom_range(T_THR, T_MAX)) : int'($urandom_range(T_MIN, T_THR - 1));
      lo = int'($urandom_range(1, 8));
    end
    send_pulse(hi, lo);
  endtask

  task automatic send_word(input logic [23:0] w, input bit std);
    for (int i = 23; i >= 0; i--) send_bit(w[i], std);
  endtask

  task automatic gap();
    model_gap();
    hold(1'b0, T_GAP + 10);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_nvalid"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_errors"}, got_err, exp_err);
    check({tag, "_frames"}, got_fd, exp_fd);
    got_q.delete();
    exp_q.delete();
    got_err = 0;
    exp_err = 0;
    got_fd  = 0;
    exp_fd  = 0;
  endtask

  initial begin
    int lat;
    logic [23:0] w;
    int n;
    int bw[4];

    din   = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rgb", 32'(rgb_data), 0);
    check("rst_led", 32'(led_num), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_dout", 32'(dout), 0);
    reset = 1'b0;
    model_reset();

    // Standard-timing word with valid latency measured on the last bit
    gap();
    w = 24'hA50F3C;
    for (int i = 23; i >= 1; i--) send_bit(w[i], 1'b1);
    model_pulse(4);
    hold(1'b1, 4);
    din = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (valid && lat < 0) lat = k;
    end
    check("valid_latency", lat, 4);
    check("first_rgb", 32'(rgb_data), 32'h00A50F3C);
    check("first_led", 32'(led_num), 0);
    gap();
    check_frame("single");

    // Eight counting words, frame_done latency on the final fall
    for (int i = 1; i <= 7; i++) send_word(24'(i), 1'b1);
    w = 24'h000008;
    for (int i = 23; i >= 1; i--) send_bit(w[i], 1'b1);
    model_pulse(4);
    hold(1'b1, 4);
    model_gap();
    din = 1'b0;
    lat = -1;
    for (int k = 1; k <= T_GAP + 20; k++) begin
      @(negedge clk);
      if (frame_done && lat < 0) lat = k;
    end
    check("frame_done_latency", lat, T_GAP + 4);
    check_frame("eight");

    // Overflow: nine words in one frame
    for (int i = 0; i < 9; i++) send_word(24'($urandom), 1'b0);
    gap();
    check_frame("overflow");

    // Width boundaries: 2 and 5 decode 0, 6 and 20 decode 1
    bw[0] = T_MIN; bw[1] = T_THR; bw[2] = T_THR - 1; bw[3] = T_MAX;
    for (int i = 0; i < 24; i++) send_pulse(bw[i % 4], 1);
    gap();
    check("boundary_rgb", 32'(rgb_data), 32'h00555555);
    check_frame("boundary");

    // Glitch inside a word, 12 more bits, then gap
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
    send_pulse(1, 5);
    for (int i = 0; i < 12; i++) send_bit(1'($urandom), 1'b0);
    gap();
    check_frame("glitch");

    // Stuck-high fault, ignored word, then recovery
    send_pulse(30, 6);
    send_word(24'($urandom), 1'b0);
    gap();
    send_word(24'($urandom), 1'b0);
    gap();
    check_frame("fault");

    // Reset mid-word discards the partial bits
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("midreset_rgb", 32'(rgb_data), 0);
    gap();
    send_word(24'hFFFFFF, 1'b0);
    gap();
    check("midreset_word", 32'(rgb_data), 32'h00FFFFFF);
    check_frame("midreset");

    // Random frames with occasional glitches
    for (int f = 0; f < 6; f++) begin
      n = int'($urandom_range(0, 10));
      for (int j = 0; j < n; j++) begin
        w = 24'($urandom);
        for (int i = 23; i >= 0; i--) begin
          if ($urandom_range(0, 40) == 0) send_pulse(1, int'($urandom_range(1, 8)));
          send_bit(w[i], 1'b0);
        end
      end
      gap();
      check_frame($sformatf("rand%0d", f));
    end

`ifdef WS2812_RX_FORWARD_EN
    check("dout_forwarded", 32'(dout_hi != 0), 1);
`else
    check("dout_tied", dout_hi, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
